// File: rtl/corrector_hamming.sv
// -----------------------------------------------------------------------------
// corrector_hamming
//
// Correction stage of an extended Hamming(8,4) decoder. It takes a received
// word together with the syndrome {s3,s2,s1} and the overall parity check st
// computed upstream. It flips the single erroneous bit, or flags a double
// error, and presents the registered result one cycle later.
//
// Handshake (both sides): a word moves across an interface on a rising edge
// where valid and ready are both 1. valid must not depend on ready. The output
// register stays stable while out_valido=1 and out_listo=0.
//
// Optional feature: define CONTADORES_ERROR_EN to build the saturating
// single/double error counters. Without it, cnt_simple and cnt_doble are
// tied to 0 and borrar_cnt is ignored.
//
// Ports
//   reloj               clock, rising edge
//   rst_n               asynchronous active-low reset
//   in_valido/in_listo  upstream handshake
//   recibido[7:0]       received word (bit 0 = overall parity)
//   s1,s2,s3,st         syndrome bits and overall parity check
//   out_valido/out_listo downstream handshake
//   corregido[7:0]      corrected word
//   dato[3:0]           data bits {c[7],c[6],c[5],c[3]}
//   pos_error[2:0]      syndrome of the registered word
//   err_simple/err_doble error class of the registered word
//   borrar_cnt          synchronous counter clear (has priority over counting)
//   cnt_simple/cnt_doble error counters, ANCHO_CNT bits, saturating
// -----------------------------------------------------------------------------
module corrector_hamming #(
    parameter int ANCHO_CNT = 8
) (
    input  logic                 reloj,
    input  logic                 rst_n,
    input  logic                 in_valido,
    output logic                 in_listo,
    input  logic [7:0]           recibido,
    input  logic                 s1,
    input  logic                 s2,
    input  logic                 s3,
    input  logic                 st,
    output logic                 out_valido,
    input  logic                 out_listo,
    output logic [7:0]           corregido,
    output logic [3:0]           dato,
    output logic [2:0]           pos_error,
    output logic                 err_simple,
    output logic                 err_doble,
    input  logic                 borrar_cnt,
    output logic [ANCHO_CNT-1:0] cnt_simple,
    output logic [ANCHO_CNT-1:0] cnt_doble
);

    logic [2:0] w_syn;
    logic       w_simple;
    logic       w_doble;
    logic [7:0] w_mascara;
    logic [7:0] w_corregido;
    logic       w_transfer;

    logic       r_valido;
    logic [7:0] r_corregido;
    logic [2:0] r_pos;
    logic       r_simple;
    logic       r_doble;

    assign w_syn    = {s3, s2, s1};
    // st=1 always means an odd number of flipped bits, so a single error.
    // The bit to flip is syn. A syndrome of 0 selects bit 0, the parity bit.
    assign w_simple = st;
    assign w_doble  = !st && (w_syn != 3'd0);
    assign w_mascara   = st ? (8'd1 << w_syn) : 8'd0;
    assign w_corregido = recibido ^ w_mascara;

    // The output slot can be refilled in the same cycle that it drains.
    assign in_listo   = !r_valido || out_listo;
    assign w_transfer = in_valido && in_listo;

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_valido    <= 1'b0;
            r_corregido <= 8'd0;
            r_pos       <= 3'd0;
            r_simple    <= 1'b0;
            r_doble     <= 1'b0;
        end else if (w_transfer) begin
            r_valido    <= 1'b1;
            r_corregido <= w_corregido;
            r_pos       <= w_syn;
            r_simple    <= w_simple;
            r_doble     <= w_doble;
        end else if (out_listo) begin
            r_valido    <= 1'b0;
        end
    end

    assign out_valido = r_valido;
    assign corregido  = r_corregido;
    assign dato       = {r_corregido[7], r_corregido[6], r_corregido[5], r_corregido[3]};
    assign pos_error  = r_pos;
    assign err_simple = r_simple;
    assign err_doble  = r_doble;

`ifdef CONTADORES_ERROR_EN
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = {ANCHO_CNT{1'b1}};

    logic [ANCHO_CNT-1:0] r_cnt_simple;
    logic [ANCHO_CNT-1:0] r_cnt_doble;

    // A clear wins over counting. A word transferred in the same cycle is
    // still corrected, but it is left out of the statistics.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_simple <= '0;
            r_cnt_doble  <= '0;
        end else if (borrar_cnt) begin
            r_cnt_simple <= '0;
            r_cnt_doble  <= '0;
        end else if (w_transfer) begin
            if (w_simple && (r_cnt_simple != CNT_MAX)) begin
                r_cnt_simple <= r_cnt_simple + 1'b1;
            end
            if (w_doble && (r_cnt_doble != CNT_MAX)) begin
                r_cnt_doble <= r_cnt_doble + 1'b1;
            end
        end
    end

    assign cnt_simple = r_cnt_simple;
    assign cnt_doble  = r_cnt_doble;
`else
    // borrar_cnt has nothing to act on in this build.
    logic w_unused_borrar;
    assign w_unused_borrar = borrar_cnt;
    assign cnt_simple      = '0;
    assign cnt_doble       = '0;
`endif

endmodule

// File: tb/tb_corrector_hamming.sv
module tb_corrector_hamming;

  localparam int W = 8;
  localparam int CNT_MAX = (1 << W) - 1;
`ifdef CONTADORES_ERROR_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic reloj = 1'b0;
  always #5 reloj = ~reloj;

  logic         rst_n;
  logic         in_valido;
  logic         in_listo;
  logic [7:0]   recibido;
  logic         s1, s2, s3, st;
  logic         out_valido;
  logic         out_listo;
  logic [7:0]   corregido;
  logic [3:0]   dato;
  logic [2:0]   pos_error;
  logic         err_simple;
  logic         err_doble;
  logic         borrar_cnt;
  logic [W-1:0] cnt_simple;
  logic [W-1:0] cnt_doble;

  corrector_hamming #(.ANCHO_CNT(W)) dut (
    .reloj      (reloj),
    .rst_n      (rst_n),
    .in_valido  (in_valido),
    .in_listo   (in_listo),
    .recibido   (recibido),
    .s1         (s1),
    .s2         (s2),
    .s3         (s3),
    .st         (st),
    .out_valido (out_valido),
    .out_listo  (out_listo),
    .corregido  (corregido),
    .dato       (dato),
    .pos_error  (pos_error),
    .err_simple (err_simple),
    .err_doble  (err_doble),
    .borrar_cnt (borrar_cnt),
    .cnt_simple (cnt_simple),
    .cnt_doble  (cnt_doble)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] rec;
    logic [2:0] syn;
    logic       st;
    logic [7:0] corr;
    logic [3:0] dato;
    logic       es;
    logic       ed;
  } vec_t;

  vec_t vecs[9];

  int n_cmp = 0;
  int n_err = 0;
  int exp_cs = 0;
  int exp_cd = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference counter model: clear has priority, saturate at CNT_MAX.
  task automatic count_model(input logic es, input logic ed, input logic clr);
    if (CNT_EN) begin
      if (clr) begin
        exp_cs = 0;
        exp_cd = 0;
      end else begin
        if (es && exp_cs < CNT_MAX) exp_cs++;
        if (ed && exp_cd < CNT_MAX) exp_cd++;
      end
    end
  endtask

  task automatic check_counters();
    chk("cnt_simple", 32'(cnt_simple), 32'(exp_cs));
    chk("cnt_doble", 32'(cnt_doble), 32'(exp_cd));
  endtask

  task automatic check_word(input vec_t v);
    chk("out_valido", 32'(out_valido), 32'd1);
    chk("corregido", 32'(corregido), 32'(v.corr));
    chk("dato", 32'(dato), 32'(v.dato));
    chk("pos_error", 32'(pos_error), 32'(v.syn));
    chk("err_simple", 32'(err_simple), 32'(v.es));
    chk("err_doble", 32'(err_doble), 32'(v.ed));
    check_counters();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valido"}, 32'(out_valido), 32'd0);
    chk({tag, "_corregido"}, 32'(corregido), 32'd0);
    chk({tag, "_dato"}, 32'(dato), 32'd0);
    chk({tag, "_pos_error"}, 32'(pos_error), 32'd0);
    chk({tag, "_err_simple"}, 32'(err_simple), 32'd0);
    chk({tag, "_err_doble"}, 32'(err_doble), 32'd0);
    chk({tag, "_cnt_simple"}, 32'(cnt_simple), 32'd0);
    chk({tag, "_cnt_doble"}, 32'(cnt_doble), 32'd0);
    chk({tag, "_in_listo"}, 32'(in_listo), 32'd1);
  endtask

  // ---------------- driver ----------------
  task automatic put_inputs(input vec_t v);
    recibido     = v.rec;
    {s3, s2, s1} = v.syn;
    st           = v.st;
  endtask

  // One transfer with the sink always ready, checked one cycle later.
  task automatic drive(input vec_t v, input logic clr);
    @(negedge reloj);
    in_valido  = 1'b1;
    out_listo  = 1'b1;
    borrar_cnt = clr;
    put_inputs(v);
    @(posedge reloj);
    count_model(v.es, v.ed, clr);
    #1;
    check_word(v);
  endtask

  task automatic idle();
    @(negedge reloj);
    in_valido  = 1'b0;
    borrar_cnt = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    //           rec     syn   st    corr    dato     es    ed
    vecs[0] = '{8'hAA, 3'd0, 1'b0, 8'hAA, 4'b1011, 1'b0, 1'b0};
    vecs[1] = '{8'h8A, 3'd5, 1'b1, 8'hAA, 4'b1011, 1'b1, 1'b0};
    vecs[2] = '{8'hAB, 3'd0, 1'b1, 8'hAA, 4'b1011, 1'b1, 1'b0};
    vecs[3] = '{8'hAC, 3'd3, 1'b0, 8'hAC, 4'b1011, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 3'd7, 1'b1, 8'hD5, 4'b1100, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 3'd1, 1'b1, 8'h02, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 3'd6, 1'b0, 8'hFF, 4'b1111, 1'b0, 1'b1};
    vecs[7] = '{8'h3C, 3'd4, 1'b1, 8'h2C, 4'b0011, 1'b1, 1'b0};
    vecs[8] = '{8'h0F, 3'd2, 1'b1, 8'h0B, 4'b0001, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valido  = 1'b0;
    out_listo  = 1'b0;
    borrar_cnt = 1'b0;
    recibido   = 8'h00;
    {s3, s2, s1} = 3'd0;
    st         = 1'b0;

    // Reset state
    repeat (2) @(posedge reloj);
    #1;
    check_zero("reset");
    @(negedge reloj);
    rst_n = 1'b1;

    // Table: back-to-back transfers with no bubble
    foreach (vecs[i]) drive(vecs[i], 1'b0);
    idle();
    @(posedge reloj);
    #1;
    chk("drain_out_valido", 32'(out_valido), 32'd0);
    chk("drain_in_listo", 32'(in_listo), 32'd1);

    // Backpressure: hold the 8A word for 3 cycles while AC waits upstream
    drive(vecs[1], 1'b0);
    @(negedge reloj);
    out_listo = 1'b0;
    in_valido = 1'b1;
    put_inputs(vecs[3]);
    for (int k = 0; k < 3; k++) begin
      @(posedge reloj);
      #1;
      chk("bp_in_listo", 32'(in_listo), 32'd0);
      check_word(vecs[1]);
    end
    @(negedge reloj);
    out_listo = 1'b1;
    @(posedge reloj);
    count_model(vecs[3].es, vecs[3].ed, 1'b0);
    #1;
    check_word(vecs[3]);
    idle();
    @(posedge reloj);
    #1;
    chk("bp_drain_out_valido", 32'(out_valido), 32'd0);

    // Reset mid-operation discards the held word
    drive(vecs[4], 1'b0);
    @(negedge reloj);
    in_valido = 1'b0;
    out_listo = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_cs = 0;
    exp_cd = 0;
    #1;
    check_zero("midrst");
    @(negedge reloj);
    rst_n = 1'b1;
    drive(vecs[0], 1'b0);
    drive(vecs[6], 1'b0);

    // Saturation of the single-error counter
    for (int k = 0; k < 300; k++) drive(vecs[5], 1'b0);
    chk("sat_cnt_simple", 32'(cnt_simple), CNT_EN ? 32'(CNT_MAX) : 32'd0);

    // Clear together with a transfer: the word is output but not counted
    drive(vecs[7], 1'b1);
    drive(vecs[3], 1'b0);
    drive(vecs[2], 1'b0);
    idle();
    @(posedge reloj);
    #1;
    chk("end_out_valido", 32'(out_valido), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/corrector_hamming.md
CORRECTOR_HAMMING -- requirements
Module: corrector_hamming

Interface
REQ-001 SHALL have parameter ANCHO_CNT, default 8, width of each error counter.
REQ-002 SHALL have port reloj, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valido, input, 1 bit: upstream word and syndrome valid.
REQ-005 SHALL have port in_listo, output, 1 bit: block can accept a word.
REQ-006 SHALL have port recibido, input, 8 bits: received Hamming word; bit 0 is overall parity, bits 1..7 are positions 1..7.
REQ-007 SHALL have ports s1, s2, s3 and st, each input, 1 bit: syndrome bits and overall parity check from the decoder stage.
REQ-008 SHALL have port out_valido, output, 1 bit: output word valid.
REQ-009 SHALL have port out_listo, input, 1 bit: downstream accepts the output word.
REQ-010 SHALL have port corregido, output, 8 bits: corrected word.
REQ-011 SHALL have port dato, output, 4 bits: extracted data {corregido[7], corregido[6], corregido[5], corregido[3]}.
REQ-012 SHALL have port pos_error, output, 3 bits: {s3, s2, s1} of the registered word.
REQ-013 SHALL have ports err_simple and err_doble, each output, 1 bit: error class of the registered word.
REQ-014 SHALL have port borrar_cnt, input, 1 bit: synchronous counter clear.
REQ-015 SHALL have ports cnt_simple and cnt_doble, each output, ANCHO_CNT bits: error counters.

Function
REQ-016 SHALL drive in_listo = !out_valido || out_listo; a transfer occurs when in_valido && in_listo.
REQ-017 SHALL register a transferred word so that it appears on the outputs with out_valido=1 on the next cycle (latency 1).
REQ-018 SHALL classify each word by syn={s3,s2,s1}: syn=0 and st=0 means no error; syn!=0 and st=1 means single error at bit syn; syn=0 and st=1 means single error at bit 0; syn!=0 and st=0 means double error.
REQ-019 SHALL flip the single erroneous bit of corregido (bit syn, or bit 0), pass recibido unchanged on a double error, and set exactly one of err_simple/err_doble only for an erroneous word.
REQ-020 SHALL hold corregido, dato, pos_error and the error flags stable while out_valido=1 and out_listo=0.
REQ-021 SHALL clear out_valido after an output handshake when no new transfer occurs that cycle; a simultaneous output handshake and input transfer SHALL load the new word with out_valido kept at 1.
REQ-022 SHALL increment cnt_simple or cnt_doble by 1 per transferred erroneous word, saturating at 2^ANCHO_CNT-1.
REQ-023 SHALL give borrar_cnt priority: both counters go to 0 and a word transferred in the same cycle is not counted, though it is still corrected and output.

Reset
REQ-024 SHALL, while rst_n=0, force out_valido=0, corregido=0, dato=0, pos_error=0, err_simple=0, err_doble=0, cnt_simple=0 and cnt_doble=0.
REQ-025 SHALL discard any in-flight word on a reset mid-operation; after release, in_listo=1 and operation resumes on the first rising edge.

Configuration
REQ-026 SHALL implement the counters only when macro CONTADORES_ERROR_EN is defined; without it, cnt_simple and cnt_doble SHALL be constant 0, borrar_cnt SHALL be ignored, and correction and handshake behaviour SHALL be unchanged.

Verification
REQ-027 SHALL cover: recibido=8'hAA, syn=0, st=0 -> next cycle corregido=8'hAA, dato=4'b1011, both error flags 0, counters unchanged.
REQ-028 SHALL cover: recibido=8'h8A, syn=5, st=1 -> corregido=8'hAA, pos_error=5, err_simple=1, cnt_simple increments by 1.
REQ-029 SHALL cover: recibido=8'hAB, syn=0, st=1 -> corregido=8'hAA, pos_error=0, err_simple=1.
REQ-030 SHALL cover: recibido=8'hAC, syn=3, st=0 -> corregido=8'hAC, err_doble=1, cnt_doble increments by 1.
REQ-031 SHALL cover backpressure: out_listo=0 for 3 cycles -> in_listo=0, outputs frozen; out_listo=1 with in_valido=1 -> next word loads with no bubble.
REQ-032 SHALL cover saturation and clear: 300 single-error words with ANCHO_CNT=8 -> cnt_simple=255; borrar_cnt=1 together with a transfer -> both counters 0 and that word uncounted.
